// File: rtl/if_prefetch_buffer_if.sv
// Bundle of instruction-memory, branch-redirect and IF/ID handshake signals
// around the prefetch buffer; master is the buffer, slave its environment.
interface if_prefetch_buffer_if;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        branch_i;
  logic [31:0] branch_target_i;
  logic        fetch_valid_o;
  logic        fetch_ready_i;
  logic [31:0] fetch_rdata_o;
  logic [31:0] fetch_addr_o;

  modport master (
    output instr_req_o, instr_addr_o, fetch_valid_o, fetch_rdata_o, fetch_addr_o,
    input  instr_gnt_i, instr_rvalid_i, instr_rdata_i, branch_i, branch_target_i,
           fetch_ready_i
  );

  modport slave (
    input  instr_req_o, instr_addr_o, fetch_valid_o, fetch_rdata_o, fetch_addr_o,
    output instr_gnt_i, instr_rvalid_i, instr_rdata_i, branch_i, branch_target_i,
           fetch_ready_i
  );
endinterface

// File: rtl/if_prefetch_buffer.sv
// Instruction prefetch buffer: issues up to DEPTH fetches, queues returned words
// with their addresses in order, and squashes in-flight responses on redirect.
module if_prefetch_buffer #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 2
) (
  input logic                   clk_i,
  input logic                   rst_i,
  if_prefetch_buffer_if.master  bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 2;
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  cnt_t          count;
  cnt_t          outstanding;
  cnt_t          discard;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   mem_data [DEPTH];
  logic [31:0]   mem_addr [DEPTH];

  cnt_t credit_used;
  logic grant;
  logic push;
  logic drop;
  logic pop;
  logic unused_tgt_lsbs;

  // count + outstanding + discard never exceeds DEPTH, so the FIFO cannot overflow
  always_comb begin
    credit_used = count + outstanding + discard;
    grant       = bus.instr_req_o && bus.instr_gnt_i;
    drop        = bus.instr_rvalid_i && (discard != '0);
    push        = bus.instr_rvalid_i && (discard == '0) && (outstanding != '0);
    pop         = bus.fetch_valid_o && bus.fetch_ready_i;
  end

  assign bus.instr_req_o   = !rst_i && !bus.branch_i && (credit_used < DEPTH_C);
  assign bus.instr_addr_o  = fetch_pc;
  assign bus.fetch_valid_o = (count != '0);
  assign bus.fetch_rdata_o = mem_data[rd_ptr];
  assign bus.fetch_addr_o  = mem_addr[rd_ptr];
  assign unused_tgt_lsbs   = ^bus.branch_target_i[1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc    <= BOOT_ADDR;
      resp_pc     <= BOOT_ADDR;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_addr[i] <= '0;
      end
    end else if (bus.branch_i) begin
      // A response arriving in the redirect cycle retires one of the squashed requests
      fetch_pc    <= {bus.branch_target_i[31:2], 2'b00};
      resp_pc     <= {bus.branch_target_i[31:2], 2'b00};
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      outstanding <= '0;
      discard     <= discard + outstanding - cnt_t'(bus.instr_rvalid_i);
    end else begin
      if (grant) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (drop) begin
        discard <= discard - cnt_t'(1);
      end
      if (push) begin
        mem_data[wr_ptr] <= bus.instr_rdata_i;
        mem_addr[wr_ptr] <= resp_pc;
        wr_ptr           <= wr_ptr + PW'(1);
        resp_pc          <= resp_pc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      outstanding <= outstanding + cnt_t'(grant) - cnt_t'(push);
      count       <= count + cnt_t'(push) - cnt_t'(pop);
    end
  end

endmodule

// File: tb/tb_if_prefetch_buffer.sv
// Bench for if_prefetch_buffer: directed scenarios plus a random run, checked
// against a transaction-level model of fetched, in-flight and queued words.
module tb_if_prefetch_buffer;
  localparam logic [31:0] BOOT  = 32'h8000_0000;
  localparam int          DEPTH = 2;

  logic clk;
  logic rst;
  if_prefetch_buffer_if bus();

  if_prefetch_buffer #(.BOOT_ADDR(BOOT), .DEPTH(DEPTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; bit stale; } fl_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } ent_t;
  typedef struct { logic [31:0] addr; int due; } mem_t;

  fl_t  inflight[$];
  ent_t exp_q[$];
  mem_t mem_q[$];
  logic [31:0] pc;
  bit   zero_ok;
  int   cyc;
  int   checks;
  int   errors;
  int   dut_grants;
  bit   granted;
  logic [31:0] gaddr;

  function automatic logic [31:0] mk(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance the model.
  task automatic cycle(input bit r, input bit br, input logic [31:0] tgt, input bit rdy,
                       input int gp, input int rp);
    bit g, rv, mreq, pop;
    logic [31:0] a;
    fl_t f;
    rst = r;
    bus.branch_i        = br;
    bus.branch_target_i = tgt;
    bus.fetch_ready_i   = rdy;
    g  = ($urandom_range(99) < gp);
    rv = !r && (mem_q.size() > 0) && (mem_q[0].due <= cyc) && ($urandom_range(99) < rp);
    bus.instr_gnt_i    = g;
    bus.instr_rvalid_i = rv;
    bus.instr_rdata_i  = rv ? mk(mem_q[0].addr) : $urandom;
    #1;
    mreq = !r && !br && (exp_q.size() + inflight.size() < DEPTH);
    chk("req", bus.instr_req_o, mreq);
    chk("addr", bus.instr_addr_o, pc);
    chk("valid", bus.fetch_valid_o, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      chk("rdata", bus.fetch_rdata_o, exp_q[0].data);
      chk("faddr", bus.fetch_addr_o, exp_q[0].addr);
    end else if (zero_ok) begin
      chk("rdata_zero", bus.fetch_rdata_o, 32'h0);
      chk("faddr_zero", bus.fetch_addr_o, 32'h0);
    end
    granted = bus.instr_req_o && g;
    gaddr   = bus.instr_addr_o;
    if (granted) dut_grants++;
    a   = bus.instr_addr_o;
    pop = (exp_q.size() != 0) && rdy && !br;
    @(posedge clk);
    if (r) begin
      exp_q.delete(); inflight.delete(); mem_q.delete();
      pc = BOOT; zero_ok = 1;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (rv) begin
        void'(mem_q.pop_front());
        f = inflight.pop_front();
        if (!br && !f.stale) begin
          exp_q.push_back('{f.addr, mk(f.addr)});
          zero_ok = 0;
        end
      end
      if (br) begin
        exp_q.delete();
        foreach (inflight[i]) inflight[i].stale = 1'b1;
        pc = {tgt[31:2], 2'b00};
      end
      if (mreq && g) begin
        inflight.push_back('{pc, 1'b0});
        mem_q.push_back('{a, cyc + 1});
        pc = pc + 32'd4;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    int g0;
    bit got_g, got_v;
    checks = 0; errors = 0; cyc = 0; dut_grants = 0;
    rst = 1'b1;
    bus.instr_gnt_i = 1'b0; bus.instr_rvalid_i = 1'b0; bus.instr_rdata_i = '0;
    bus.branch_i = 1'b0; bus.branch_target_i = '0; bus.fetch_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    pc = BOOT; zero_ok = 1;
    chk("rst_req", bus.instr_req_o, 1'b0);
    chk("rst_addr", bus.instr_addr_o, BOOT);
    chk("rst_valid", bus.fetch_valid_o, 1'b0);
    chk("rst_rdata", bus.fetch_rdata_o, 32'h0);
    chk("rst_faddr", bus.fetch_addr_o, 32'h0);

    // Streaming from boot address
    repeat (12) cycle(0, 0, '0, 1, 100, 100);

    // IF/ID stalled from reset: only DEPTH grants, then drain in order
    cycle(1, 0, '0, 0, 100, 0);
    g0 = dut_grants;
    repeat (8) cycle(0, 0, '0, 0, 100, 100);
    chk("stall_grants", dut_grants - g0, DEPTH);
    repeat (6) cycle(0, 0, '0, 1, 100, 100);

    // Request held while grant withheld
    cycle(0, 1, 32'h0000_0010, 1, 100, 100);
    repeat (4) cycle(0, 0, '0, 1, 0, 100);
    repeat (3) begin
      chk("hold_req", bus.instr_req_o, 1'b1);
      chk("hold_addr", bus.instr_addr_o, 32'h0000_0010);
      cycle(0, 0, '0, 1, 0, 100);
    end
    cycle(0, 0, '0, 1, 100, 100);
    chk("after_gnt_addr", bus.instr_addr_o, 32'h0000_0014);
    repeat (4) cycle(0, 0, '0, 1, 100, 100);

    // Branch with two requests in flight
    cycle(1, 0, '0, 1, 0, 0);
    cycle(0, 0, '0, 1, 100, 0);
    cycle(0, 0, '0, 1, 100, 0);
    cycle(0, 1, 32'h0000_0103, 1, 100, 0);
    got_g = 0; got_v = 0;
    repeat (10) begin
      if (!got_v && bus.fetch_valid_o) begin
        got_v = 1;
        chk("br_first_faddr", bus.fetch_addr_o, 32'h0000_0100);
      end
      cycle(0, 0, '0, 1, 100, 100);
      if (!got_g && granted) begin
        got_g = 1;
        chk("br_first_req", gaddr, 32'h0000_0100);
      end
    end
    chk("br_saw_grant", got_g, 1'b1);
    chk("br_saw_valid", got_v, 1'b1);

    // Branch coincident with rvalid and pop in steady state
    repeat (6) cycle(0, 0, '0, 1, 100, 100);
    cycle(0, 1, 32'h0000_2000, 1, 100, 100);
    repeat (8) cycle(0, 0, '0, 1, 100, 100);

    // Random traffic, redirects near the address wrap, occasional reset
    for (int i = 0; i < 3000; i++) begin
      bit r, br;
      logic [31:0] t;
      r  = ($urandom_range(199) == 0);
      br = !r && ($urandom_range(14) == 0);
      t  = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(15))) : $urandom;
      cycle(r, br, t, $urandom_range(3) != 0, (i < 1500) ? 70 : 95, (i < 1500) ? 60 : 90);
    end

    // Reset with the FIFO full and nothing in flight
    cycle(0, 1, 32'h0000_0400, 0, 100, 100);
    repeat (8) cycle(0, 0, '0, 0, 100, 100);
    chk("full_valid", bus.fetch_valid_o, 1'b1);
    chk("full_req", bus.instr_req_o, 1'b0);
    cycle(1, 0, '0, 0, 100, 0);
    chk("rst2_req", bus.instr_req_o, 1'b0);
    chk("rst2_addr", bus.instr_addr_o, BOOT);
    chk("rst2_valid", bus.fetch_valid_o, 1'b0);
    chk("rst2_rdata", bus.fetch_rdata_o, 32'h0);
    chk("rst2_faddr", bus.fetch_addr_o, 32'h0);
    rst = 1'b0;
    bus.fetch_ready_i = 1'b1;
    #1;
    chk("rel_req", bus.instr_req_o, 1'b1);
    chk("rel_addr", bus.instr_addr_o, BOOT);
    repeat (6) cycle(0, 0, '0, 1, 100, 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
